// File: rtl/nova_bus_pkg.sv
// Shared definitions for the phi2 bus sequencer family.
//   - DEF_* constants : default bus-cycle geometry
//   - strobe_t        : registered one-cycle strobes produced per bus cycle
//   - clog2()         : counter width helper (never returns less than 1)
//   - params_ok()     : elaboration-time legality check of the cycle geometry
package nova_bus_pkg;

    localparam int DEF_PERIOD      = 10;
    localparam int DEF_HIGH_START  = 5;
    localparam int DEF_ADDR_SAMPLE = 2;
    localparam int DEF_MAX_STRETCH = 15;

    typedef struct packed {
        logic rise;
        logic fall;
        logic dvalid;
    } strobe_t;

    // Width needed to hold values 0..n-1; a 1-bit minimum keeps a
    // MAX_STRETCH of 0 from producing a zero-width counter.
    function automatic int clog2(input int n);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

    function automatic bit params_ok(input int period,
                                     input int high_start,
                                     input int addr_sample,
                                     input int max_stretch,
                                     input int addr_w,
                                     input int data_w);
        return (period >= 4) && (period <= 64) &&
               (high_start >= 1) && (high_start <= period - 1) &&
               (addr_sample >= 0) && (addr_sample < high_start) &&
               (max_stretch >= 0) && (addr_w >= 1) && (data_w >= 1);
    endfunction

endpackage

// File: rtl/phi2_bus_sequencer_if.sv
// CPU-side bus bundle of the phi2 bus sequencer.
//   master : drives a, d, stretchReq, haltReq; observes timing and captures
//   slave  : the sequencer itself
// Signal names follow the CPU pin naming used by the rest of the board.
interface phi2_bus_sequencer_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8,
    parameter int CNT_W  = 4
);
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    logic              stretchReq;
    logic              haltReq;
    logic              phi2;
    logic              phi2Rise;
    logic              phi2Fall;
    logic [ADDR_W-1:0] addrQ;
    logic              addrValid;
    logic [DATA_W-1:0] dataQ;
    logic              dataValid;
    logic              halted;
    logic [CNT_W-1:0]  stretchCnt;

    modport master (
        output a, d, stretchReq, haltReq,
        input  phi2, phi2Rise, phi2Fall, addrQ, addrValid,
               dataQ, dataValid, halted, stretchCnt
    );

    modport slave (
        input  a, d, stretchReq, haltReq,
        output phi2, phi2Rise, phi2Fall, addrQ, addrValid,
               dataQ, dataValid, halted, stretchCnt
    );
endinterface

// File: rtl/phi2_phase_counter.sv
// Bus-cycle phase counter.
//   clk_i, rst_ni   : clock, asynchronous active-low reset
//   stretch_req_i   : hold the last high state (honoured only in state PERIOD-1)
//   halt_req_i      : park in state 0 (honoured only in state 0)
//   state_o         : current state 0..PERIOD-1
//   state_nxt_o     : state that will be loaded on the next edge
//   advance_o       : final high cycle, counter wraps to 0 on this edge
//   halted_o        : sequencer is parked in state 0
//   stretch_cnt_o   : wait states used in the current bus cycle
module phi2_phase_counter
    import nova_bus_pkg::*;
#(
    parameter int  PERIOD      = DEF_PERIOD,
    parameter int  MAX_STRETCH = DEF_MAX_STRETCH,
    localparam int SW          = clog2(PERIOD),
    localparam int CW          = clog2(MAX_STRETCH + 1)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          stretch_req_i,
    input  logic          halt_req_i,
    output logic [SW-1:0] state_o,
    output logic [SW-1:0] state_nxt_o,
    output logic          advance_o,
    output logic          halted_o,
    output logic [CW-1:0] stretch_cnt_o
);

    localparam logic [SW-1:0] LAST  = SW'(PERIOD - 1);
    localparam logic [CW-1:0] MAX_S = CW'(MAX_STRETCH);

    logic [SW-1:0] state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          halted_q, halted_d;
    logic          adv;

    always_comb begin
        state_d  = state_q + SW'(1);
        cnt_d    = cnt_q;
        halted_d = 1'b0;
        adv      = 1'b0;
        if (state_q == '0) begin
            cnt_d = '0;
            if (halt_req_i) begin
                state_d  = '0;
                halted_d = 1'b1;
            end
        end else if (state_q == LAST) begin
            // Wait states are bounded: once MAX_S is used the cycle
            // completes even if the request is still asserted.
            if (stretch_req_i && (cnt_q < MAX_S)) begin
                state_d = state_q;
                cnt_d   = cnt_q + CW'(1);
            end else begin
                state_d = '0;
                cnt_d   = '0;
                adv     = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= '0;
            cnt_q    <= '0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            halted_q <= halted_d;
        end
    end

    assign state_o       = state_q;
    assign state_nxt_o   = state_d;
    assign advance_o     = adv;
    assign halted_o      = halted_q;
    assign stretch_cnt_o = cnt_q;

endmodule

// File: rtl/phi2_bus_sequencer.sv
// 6502-style bus-cycle sequencer.
//   fpgaClk : system clock
//   resetN  : asynchronous active-low reset
//   bus     : CPU-side bundle (slave modport)
//             in : a, d, stretchReq, haltReq
//             out: phi2, phi2Rise, phi2Fall, addrQ, addrValid, dataQ,
//                  dataValid, halted, stretchCnt
// Every output is a flop: phi2 and the strobes are loaded from the counter's
// next state so they line up exactly with the state they describe.
module phi2_bus_sequencer
    import nova_bus_pkg::*;
#(
    parameter int PERIOD      = DEF_PERIOD,
    parameter int HIGH_START  = DEF_HIGH_START,
    parameter int ADDR_SAMPLE = DEF_ADDR_SAMPLE,
    parameter int MAX_STRETCH = DEF_MAX_STRETCH,
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 8
) (
    input  logic                 fpgaClk,
    input  logic                 resetN,
    phi2_bus_sequencer_if.slave  bus
);

    localparam int SW = clog2(PERIOD);
    localparam int CW = clog2(MAX_STRETCH + 1);

    localparam logic [SW-1:0] HS = SW'(HIGH_START);
    localparam logic [SW-1:0] AS = SW'(ADDR_SAMPLE);

    if (!params_ok(PERIOD, HIGH_START, ADDR_SAMPLE, MAX_STRETCH, ADDR_W, DATA_W))
    begin : g_bad_params
        $error("phi2_bus_sequencer: illegal PERIOD/HIGH_START/ADDR_SAMPLE/MAX_STRETCH");
    end

    logic [SW-1:0] state, state_nxt;
    logic          adv;
    logic          halted;
    logic [CW-1:0] scnt;

    phi2_phase_counter #(
        .PERIOD      (PERIOD),
        .MAX_STRETCH (MAX_STRETCH)
    ) u_phase (
        .clk_i         (fpgaClk),
        .rst_ni        (resetN),
        .stretch_req_i (bus.stretchReq),
        .halt_req_i    (bus.haltReq),
        .state_o       (state),
        .state_nxt_o   (state_nxt),
        .advance_o     (adv),
        .halted_o      (halted),
        .stretch_cnt_o (scnt)
    );

    logic              phi2_q, phi2_d;
    strobe_t           stb_q, stb_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              avalid_q, avalid_d;
    logic [DATA_W-1:0] data_q, data_d;

    always_comb begin
        phi2_d = (state_nxt >= HS);
        // Guarded so a stretched HIGH_START == PERIOD-1 pulses only once.
        stb_d.rise   = (state_nxt == HS) && (state != HS);
        stb_d.fall   = adv;
        stb_d.dvalid = adv;

        addr_d   = addr_q;
        avalid_d = avalid_q;
        // Only capture when leaving the sample state, so a halted state 0
        // (ADDR_SAMPLE == 0) does not keep reloading the address.
        if ((state == AS) && (state_nxt != state)) begin
            addr_d   = bus.a;
            avalid_d = 1'b1;
        end
        if (state_nxt == '0) avalid_d = 1'b0;

        data_d = adv ? bus.d : data_q;
    end

    always_ff @(posedge fpgaClk or negedge resetN) begin
        if (!resetN) begin
            phi2_q   <= 1'b0;
            stb_q    <= '0;
            addr_q   <= '0;
            avalid_q <= 1'b0;
            data_q   <= '0;
        end else begin
            phi2_q   <= phi2_d;
            stb_q    <= stb_d;
            addr_q   <= addr_d;
            avalid_q <= avalid_d;
            data_q   <= data_d;
        end
    end

    assign bus.phi2       = phi2_q;
    assign bus.phi2Rise   = stb_q.rise;
    assign bus.phi2Fall   = stb_q.fall;
    assign bus.addrQ      = addr_q;
    assign bus.addrValid  = avalid_q;
    assign bus.dataQ      = data_q;
    assign bus.dataValid  = stb_q.dvalid;
    assign bus.halted     = halted;
    assign bus.stretchCnt = scnt;

endmodule
